// File: rtl/postif_id_pkg.sv
// Shared types and constants for the postif -> id pipeline register.
package postif_id_pkg;

  localparam int unsigned PcWidth   = 32;
  localparam int unsigned InstWidth = 32;
  localparam int unsigned ExcWidth  = 32;

  localparam logic [InstWidth-1:0] NopInst = 32'h0;

  // IDLE: nothing outstanding, WAIT: read issued, CANCEL: flushed read still due
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCancel
  } state_e;

  typedef struct packed {
    logic [PcWidth-1:0]   pc;
    logic [InstWidth-1:0] inst;
    logic [ExcWidth-1:0]  exc;
    logic                 valid;
  } id_entry_t;

  localparam id_entry_t BubbleEntry = '0;

endpackage

// File: rtl/postif_id_if.sv
// Fetch/decode boundary signals between postif, the pipeline register and id.
// id_bubble_cnt_o exists only when POSTIF_ID_PERF_CNT_EN is defined.
interface postif_id_if;

  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] exception_type_i;
  logic        inst_ren_i;
  logic        inst_ok_i;
  logic        inst_valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_exception_type_o;
  logic        id_valid_o;
  logic        stall_req_o;
`ifdef POSTIF_ID_PERF_CNT_EN
  logic [31:0] id_bubble_cnt_o;
`endif

  modport master (
    output pc_i, inst_i, exception_type_i, inst_ren_i, inst_ok_i, inst_valid_i,
    output stall_i, flush_i,
`ifdef POSTIF_ID_PERF_CNT_EN
    input  id_bubble_cnt_o,
`endif
    input  id_pc_o, id_inst_o, id_exception_type_o, id_valid_o, stall_req_o
  );

  modport slave (
    input  pc_i, inst_i, exception_type_i, inst_ren_i, inst_ok_i, inst_valid_i,
    input  stall_i, flush_i,
`ifdef POSTIF_ID_PERF_CNT_EN
    output id_bubble_cnt_o,
`endif
    output id_pc_o, id_inst_o, id_exception_type_o, id_valid_o, stall_req_o
  );

endinterface

// File: rtl/postif_id_hold.sv
// Single-entry buffer for a cache reply that lands while id is stalled.
// Clear has priority over load; load and consume never coincide in use.
module postif_id_hold
  import postif_id_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  logic      consume_i,
  input  logic      clear_i,
  input  id_entry_t data_i,
  output logic      valid_o,
  output id_entry_t data_o
);

  logic      valid_q;
  id_entry_t data_q;

  // Occupancy flag: clear beats load beats consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload captured only on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= BubbleEntry;
    end else if (load_i && !clear_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/postif_id.sv
// postif -> id pipeline register with instruction-cache wait tracking.
// Optional bubble counter enabled by defining POSTIF_ID_PERF_CNT_EN.
module postif_id
  import postif_id_pkg::*;
(
  input logic         clk,
  input logic         rst,
  postif_id_if.slave  bus
);

  state_e    state_q, state_d;
  id_entry_t id_q, id_d;
  id_entry_t live_entry, fault_entry, hold_data;
  logic      hold_valid, hold_load, hold_consume;
  logic      reply_live, fault, advance;

  // A reply counts only for a read we actually own: outstanding, or a same-cycle hit.
  // Stray inst_ok_i with nothing requested is ignored.
  assign reply_live = bus.inst_ok_i &&
                      ((state_q == StWait) || ((state_q == StIdle) && bus.inst_ren_i));
  assign fault      = !bus.inst_ren_i && (bus.exception_type_i != '0);
  assign advance    = !bus.stall_i && !bus.flush_i;

  assign live_entry  = '{pc: bus.pc_i, inst: bus.inst_i, exc: bus.exception_type_i,
                         valid: bus.inst_valid_i};
  assign fault_entry = '{pc: bus.pc_i, inst: NopInst, exc: bus.exception_type_i,
                         valid: 1'b1};

  assign hold_load    = bus.stall_i && !bus.flush_i && reply_live && !hold_valid;
  assign hold_consume = advance && hold_valid;

  postif_id_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hold_load),
    .consume_i (hold_consume),
    .clear_i   (bus.flush_i),
    .data_i    (live_entry),
    .valid_o   (hold_valid),
    .data_o    (hold_data)
  );

  // Cache-read tracking; a flush that coincides with the reply returns straight to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.inst_ren_i && !bus.inst_ok_i) state_d = StWait;
      StWait: begin
        if (bus.inst_ok_i)     state_d = StIdle;
        else if (bus.flush_i)  state_d = StCancel;
      end
      StCancel: if (bus.inst_ok_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // id slot source select: flush, hold, live reply, fetch fault, else bubble
  always_comb begin
    id_d = id_q;
    if (bus.flush_i) begin
      id_d = BubbleEntry;
    end else if (advance) begin
      if (hold_valid)      id_d = hold_data;
      else if (reply_live) id_d = live_entry;
      else if (fault)      id_d = fault_entry;
      else                 id_d = BubbleEntry;
    end
  end

  // State and id slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= BubbleEntry;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign bus.id_pc_o             = id_q.pc;
  assign bus.id_inst_o           = id_q.inst;
  assign bus.id_exception_type_o = id_q.exc;
  assign bus.id_valid_o          = id_q.valid;
  // Held reply means pc is already frozen upstream; no need to stall for the live read
  assign bus.stall_req_o = (state_q == StCancel) ||
                           (bus.inst_ren_i && !bus.inst_ok_i && !hold_valid);

`ifdef POSTIF_ID_PERF_CNT_EN
  logic        load_bubble;
  logic [31:0] bubble_cnt_q;

  assign load_bubble = advance && !hold_valid && !reply_live && !fault;

  // Count advance cycles that load a bubble (flush cycles excluded), wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (load_bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.id_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_postif_id.sv
// Directed-vector bench for postif_id with a queue-based scoreboard.
module tb_postif_id;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
    logic        valid;
    logic        sreq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t  exp_q[$];
  string name_q[$];

  postif_id_if bus ();

  postif_id u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: outputs visible during a cycle are compared at its falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (bus.id_pc_o !== e.pc || bus.id_inst_o !== e.inst ||
          bus.id_exception_type_o !== e.exc || bus.id_valid_o !== e.valid ||
          bus.stall_req_o !== e.sreq) begin
        n_err++;
        $display("FAIL %s: got pc=%h inst=%h exc=%h valid=%b sreq=%b, want pc=%h inst=%h exc=%h valid=%b sreq=%b",
                 nm, bus.id_pc_o, bus.id_inst_o, bus.id_exception_type_o, bus.id_valid_o,
                 bus.stall_req_o, e.pc, e.inst, e.exc, e.valid, e.sreq);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue what must be seen
  task automatic cyc(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] exc, input logic ren, input logic ok,
                     input logic vld, input logic stl, input logic fl,
                     input logic [31:0] e_pc, input logic [31:0] e_inst,
                     input logic [31:0] e_exc, input logic e_valid, input logic e_sreq,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.pc_i             = pc;
    bus.inst_i           = inst;
    bus.exception_type_i = exc;
    bus.inst_ren_i       = ren;
    bus.inst_ok_i        = ok;
    bus.inst_valid_i     = vld;
    bus.stall_i          = stl;
    bus.flush_i          = fl;
    e.pc = e_pc; e.inst = e_inst; e.exc = e_exc; e.valid = e_valid; e.sreq = e_sreq;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    bus.pc_i = '0; bus.inst_i = '0; bus.exception_type_i = '0;
    bus.inst_ren_i = 1'b0; bus.inst_ok_i = 1'b0; bus.inst_valid_i = 1'b0;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);

    //   rst pc            inst          exc   ren ok vld stl fl | exp pc      inst          exc  v sreq
    cyc(1, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "reset");
    // Hit
    cyc(0, 32'hBFC00000, 32'h24010001, 32'h0, 1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "hit_req");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'hBFC00000, 32'h24010001, 32'h0, 1, 0, "hit_load");
    // Three-cycle miss
    cyc(0, 32'hBFC00004, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "miss_w1");
    cyc(0, 32'hBFC00004, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "miss_w2");
    cyc(0, 32'hBFC00004, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "miss_w3");
    cyc(0, 32'hBFC00004, 32'h3C1D8000, 32'h0, 1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "miss_reply");
    // Reply arrives while id is stalled
    cyc(0, 32'hBFC00008, 32'h0,        32'h0, 1, 0, 0, 1, 0, 32'hBFC00004, 32'h3C1D8000, 32'h0, 1, 1, "miss_load");
    cyc(0, 32'hBFC00008, 32'h8C020004, 32'h0, 1, 1, 1, 1, 0, 32'hBFC00004, 32'h3C1D8000, 32'h0, 1, 0, "stall_reply");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 1, 0, 32'hBFC00004, 32'h3C1D8000, 32'h0, 1, 0, "stall_hold");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'hBFC00004, 32'h3C1D8000, 32'h0, 1, 0, "release");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'hBFC00008, 32'h8C020004, 32'h0, 1, 0, "held_load");
    // Flush during WAIT, reply two cycles later is dropped
    cyc(0, 32'hBFC00010, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "flw_req");
    cyc(0, 32'hBFC00010, 32'h0,        32'h0, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0, 0, 1, "flush");
    cyc(0, 32'hBFC00100, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "cancel_wait");
    cyc(0, 32'hBFC00100, 32'hDEADBEEF, 32'h0, 0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "cancel_reply");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "cancel_drop");
    // Fetch fault
    cyc(0, 32'hBFC00200, 32'h0,        32'h4, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "fault_req");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'hBFC00200, 32'h0,        32'h4, 1, 0, "fault_load");
    // Flush coincident with reply in WAIT: dropped and back to IDLE
    cyc(0, 32'hBFC00300, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 1, "flok_req");
    cyc(0, 32'hBFC00300, 32'hCAFEF00D, 32'h0, 1, 1, 1, 0, 1, 32'h0,        32'h0,        32'h0, 0, 0, "flok_both");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "flok_drop");
    cyc(0, 32'hBFC00304, 32'h0000000F, 32'h0, 1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "flok_idle_hit");
    // Stall keeps a real instruction in id while a new miss starts, then reset
    cyc(0, 32'hBFC00400, 32'h0,        32'h0, 1, 0, 0, 1, 0, 32'hBFC00304, 32'h0000000F, 32'h0, 1, 1, "pre_reset");
    cyc(1, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "reset_mid_wait");
    cyc(0, 32'hBFC00400, 32'hBAD0BAD0, 32'h0, 0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "stray_ok");
    cyc(0, 32'h0,        32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, "stray_ignored");

    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
